// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 encodings, FSM states and the op legality check shared by the LSU.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;

  // Unknown funct3, or halfword/word not naturally aligned.
  function automatic logic op_bad(input logic [2:0] f3, input logic [1:0] off);
    return (f3 inside {3'b011, 3'b110, 3'b111}) ||
           (f3[1:0] == 2'b01 && off[0]) ||
           (f3 == F3_W && off != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// load_store_unit_align: store lane replication/byte enables, load shift/extend, legality check.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata_in,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata_in,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] ld_data,
  output logic        bad
);

  logic [31:0] sh;

  always_comb begin
    bad      = op_bad(st_funct3, st_off);
    st_wdata = st_funct3[1:0] == 2'b00 ? {4{st_wdata_in[7:0]}} :
               st_funct3[1:0] == 2'b01 ? {2{st_wdata_in[15:0]}} : st_wdata_in;
    st_be    = st_funct3[1:0] == 2'b00 ? 4'b0001 << st_off :
               st_funct3[1:0] == 2'b01 ? (st_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    sh       = ld_rdata_in >> {ld_off, 3'b000};
    ld_data  = ld_funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
               ld_funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
               ld_funct3 == F3_BU ? {24'd0, sh[7:0]} :
               ld_funct3 == F3_HU ? {16'd0, sh[15:0]} : sh;
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator over a req/gnt/rvalid data-memory handshake.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ls_valid,
  input  logic              ls_we,
  input  logic [2:0]        ls_funct3,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_stall,
  output logic              ls_done,
  output logic              ls_fault,
  output logic [31:0]       ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-3:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d, fault_q, fault_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       st_wdata, ld_data;
  logic [3:0]        st_be;
  logic              bad, expired;

  load_store_unit_align u_align (
    .st_funct3  (ls_funct3),
    .st_off     (ls_addr[1:0]),
    .st_wdata_in(ls_wdata),
    .ld_funct3  (f3_q),
    .ld_off     (off_q),
    .ld_rdata_in(mem_rdata),
    .st_wdata   (st_wdata),
    .st_be      (st_be),
    .ld_data    (ld_data),
    .bad        (bad)
  );

  assign expired = cnt_q == CNT_W'(TIMEOUT - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q == S_REQ || state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    fault_d     = 1'b0;
    rdata_d     = '0;
    case (state_q)
      S_IDLE: if (ls_valid) begin
        if (bad) begin
          state_d = S_DONE;
          fault_d = 1'b1;
        end else begin
          state_d     = S_REQ;
          we_d        = ls_we;
          f3_d        = ls_funct3;
          off_d       = ls_addr[1:0];
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr[ADDR_W-1:2];
          mem_be_d    = ls_we ? st_be : 4'b0000;
          mem_wdata_d = st_wdata;
        end
      end
      S_REQ: if (mem_gnt) begin
        mem_req_d = 1'b0;
        state_d   = we_q ? S_DONE : S_WAIT;
        cnt_d     = '0;
      end else if (expired) begin
        mem_req_d = 1'b0;
        state_d   = S_DONE;
        fault_d   = 1'b1;
      end
      S_WAIT: if (mem_rvalid) begin
        rdata_d = ld_data;
        state_d = S_DONE;
      end else if (expired) begin
        state_d = S_DONE;
        fault_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = state_d == S_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ls_stall  = ls_valid & ~done_q;
  assign ls_done   = done_q;
  assign ls_fault  = fault_q;
  assign ls_rdata  = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
